wb_sram_responder: RTL and testbench



---
 rtl/wb_resp_pkg.sv | 28 ++
 rtl/wb_resp_ram.sv | 24 ++
 rtl/wb_sram_responder.sv | 112 +++++++++++
 tb/tb_wb_sram_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_resp_pkg.sv
// Shared types and helpers for the Wishbone SRAM/IRQ responder and its formal model.
package wb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int IRQ_BIT = 0;

  function automatic int unsigned clamp_wait(input int unsigned wait_cfg,
                                             input int unsigned max_wait);
    return (wait_cfg > max_wait) ? max_wait : wait_cfg;
  endfunction

  // Byte-lane merge of a write into an existing word; lanes with sel=0 keep old data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_resp_ram.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
module wb_resp_ram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        be,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone classic responder: byte-writable RAM window plus one IRQ control register,
// with a programmable number of wait states per transaction.
module wb_sram_responder
  import wb_resp_pkg::*;
#(
  parameter int          RAM_AW   = 10,
  parameter logic [29:0] RAM_BASE = 30'h0000_0000,
  parameter logic [29:0] IRQ_ADDR = 30'h2000_0000,
  parameter int          MAX_WAIT = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bus__cyc,
  input  logic                              bus__stb,
  input  logic                              bus__we,
  input  logic [3:0]                        bus__sel,
  input  logic [29:0]                       bus__adr,
  input  logic [31:0]                       bus__dat_w,
  output logic [31:0]                       bus__dat_r,
  output logic                              bus__ack,
  input  logic [$clog2(MAX_WAIT+1)-1:0]     wait_cfg,
  output logic                              irq,
  output logic                              busy
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [29:0]       adr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;

  logic              ram_hit;
  logic              irq_hit;
  logic              commit;
  logic [3:0]        ram_be;
  logic [31:0]       ram_rdata;

  assign ram_hit = (adr_q[29:RAM_AW] == RAM_BASE[29:RAM_AW]);
  assign irq_hit = (adr_q == IRQ_ADDR);

  // The access happens on the WAIT->ACK edge; rst blocks it so a reset drops the write.
  assign commit = (state == WAIT) && bus__cyc && (cnt == '0) && !rst;
  assign ram_be = (we_q && ram_hit) ? sel_q : 4'b0000;
  assign busy   = (state != IDLE);

  // Request latch: stable from acceptance through the ACK cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && bus__cyc && bus__stb) begin
      adr_q <= bus__adr;
      we_q  <= bus__we;
      sel_q <= bus__sel;
      dat_q <= bus__dat_w;
    end
  end

  // Control FSM: IDLE -> WAIT (cnt cycles) -> ACK -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus__ack <= 1'b0;
      irq      <= 1'b0;
    end else begin
      bus__ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus__cyc && bus__stb) begin
            cnt   <= WAIT_W'(clamp_wait(32'(wait_cfg), MAX_WAIT));
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!bus__cyc) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state    <= ACK;
            bus__ack <= 1'b1;
            if (we_q && irq_hit && sel_q[0]) irq <= dat_q[IRQ_BIT];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  wb_resp_ram #(
    .RAM_AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (commit && ram_hit),
    .be    (ram_be),
    .addr  (adr_q[RAM_AW-1:0]),
    .wdata (dat_q),
    .rdata (ram_rdata)
  );

  // Read data is forced to zero outside the ACK cycle
  always_comb begin
    bus__dat_r = 32'h0;
    if (bus__ack) begin
      if (ram_hit)      bus__dat_r = ram_rdata;
      else if (irq_hit) bus__dat_r = 32'(irq) << IRQ_BIT;
    end
  end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Scoreboard bench for wb_sram_responder: expected read data is queued at drive time.
module tb_wb_sram_responder;

  localparam int          AW    = 10;
  localparam int          MW    = 5;
  localparam int          WW    = 3;
  localparam logic [29:0] IRQ_A = 30'h2000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [29:0]   adr;
  logic [31:0]   dat_w;
  logic [31:0]   dat_r;
  logic          ack;
  logic [WW-1:0] wait_cfg;
  logic          irq;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mdl [0:(2**AW)-1];
  logic        mdl_irq;

  always #5 clk = ~clk;

  wb_sram_responder #(
    .RAM_AW   (AW),
    .RAM_BASE (30'h0),
    .IRQ_ADDR (IRQ_A),
    .MAX_WAIT (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus__cyc   (cyc),
    .bus__stb   (stb),
    .bus__we    (we),
    .bus__sel   (sel),
    .bus__adr   (adr),
    .bus__dat_w (dat_w),
    .bus__dat_r (dat_r),
    .bus__ack   (ack),
    .wait_cfg   (wait_cfg),
    .irq        (irq),
    .busy       (busy)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    if (s[0]) r[7:0]   = n[7:0];
    if (s[1]) r[15:8]  = n[15:8];
    if (s[2]) r[23:16] = n[23:16];
    if (s[3]) r[31:24] = n[31:24];
    return r;
  endfunction

  // One bus transaction; returns ack status, latency in edges from acceptance edge
  // (edge N counts as 1), read data, irq before/at ack and whether ack lasted >1 cycle.
  task automatic xfer(input logic w, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [WW-1:0] wc,
                      output bit acked, output int lat, output logic [31:0] rd,
                      output logic irq_pre, output logic irq_ack, output logic wide);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; wait_cfg = wc;
    acked = 0; lat = 0; rd = '0; irq_pre = 1'bx; irq_ack = 1'bx; wide = 1'b0;
    for (int k = 1; k <= 40 && !acked; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        irq_pre  = irq;
        wait_cfg = ~wc;
      end
      if (ack) begin
        acked = 1; lat = k; rd = dat_r; irq_ack = irq;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (acked) begin
      @(posedge clk); #1;
      wide = ack;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ack !== 1'b0)      begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
    total++; if (dat_r !== 32'h0)   begin bad++; $display("FAIL reset_dat_r: got %h want 0", dat_r); end
    total++; if (irq !== 1'b0)      begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    mdl_irq = 1'b0;
  endtask

  task automatic test_byte_lanes();
    bit a; int l; logic [31:0] rd; logic ip, ia, wd;
    xfer(1'b1, 30'h10, 32'hAABBCCDD, 4'b1111, 3'd0, a, l, rd, ip, ia, wd);
    mdl[10'h10] = 32'hAABBCCDD;
    total++; if (!a) begin bad++; $display("FAIL bl_wr1_ack: got 0 want 1"); end
    xfer(1'b1, 30'h10, 32'h11223344, 4'b0011, 3'd0, a, l, rd, ip, ia, wd);
    mdl[10'h10] = merge(mdl[10'h10], 32'h11223344, 4'b0011);
    total++; if (!a) begin bad++; $display("FAIL bl_wr2_ack: got 0 want 1"); end
    exp_q.push_back(32'hAABB3344);
    xfer(1'b0, 30'h10, 32'h0, 4'b0001, 3'd0, a, l, rd, ip, ia, wd);
    total++;
    if (!a) begin bad++; $display("FAIL bl_rd_ack: got 0 want 1"); void'(exp_q.pop_front()); end
    else begin
      logic [31:0] e; e = exp_q.pop_front();
      if (rd !== e) begin bad++; $display("FAIL bl_rd_data: got %h want %h", rd, e); end
    end
    total++; if (dat_r !== 32'h0) begin bad++; $display("FAIL bl_dat_r_idle: got %h want 0", dat_r); end
  endtask

  task automatic test_back_to_back();
    bit a; int l; logic [31:0] rd; logic ip, ia, wd;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d; d = $urandom;
      xfer(1'b1, 30'h40 + 30'(i), d, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
      mdl[10'h40 + 10'(i)] = d;
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d; logic [3:0] s;
      d = $urandom; s = 4'($urandom_range(0, 15));
      xfer(1'b1, 30'h40 + 30'(i), d, s, 3'd0, a, l, rd, ip, ia, wd);
      mdl[10'h40 + 10'(i)] = merge(mdl[10'h40 + 10'(i)], d, s);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(mdl[10'h40 + 10'(i)]);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] e;
      xfer(1'b0, 30'h40 + 30'(i), 32'h0, 4'b0000, 3'd0, a, l, rd, ip, ia, wd);
      e = exp_q.pop_front();
      total++;
      if (!a)           begin bad++; $display("FAIL b2b_rd_ack[%0d]: got no ack want ack", i); end
      else if (rd !== e) begin bad++; $display("FAIL b2b_rd_data[%0d]: got %h want %h", i, rd, e); end
      total++; if (l !== 2) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 2", i, l); end
    end
  endtask

  task automatic test_wait_states();
    bit a; int l; logic [31:0] rd; logic ip, ia, wd;
    logic [WW-1:0] cfgs [4];
    cfgs[0] = 3'd0; cfgs[1] = 3'd3; cfgs[2] = 3'd7; cfgs[3] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      int w; logic [31:0] e;
      w = (int'(cfgs[i]) > MW) ? MW : int'(cfgs[i]);
      exp_q.push_back(mdl[10'h10]);
      xfer(1'b0, 30'h10, 32'h0, 4'hF, cfgs[i], a, l, rd, ip, ia, wd);
      e = exp_q.pop_front();
      total++; if (l !== 2 + w) begin bad++; $display("FAIL ws_latency[cfg=%0d]: got %0d want %0d", cfgs[i], l, 2 + w); end
      total++; if (wd !== 1'b0) begin bad++; $display("FAIL ws_ack_width[cfg=%0d]: got wide=%b want 0", cfgs[i], wd); end
      total++; if (rd !== e)    begin bad++; $display("FAIL ws_rd_data[cfg=%0d]: got %h want %h", cfgs[i], rd, e); end
    end
  endtask

  task automatic test_abort();
    bit a; int l; logic [31:0] rd; logic ip, ia, wd; logic seen_ack; logic [31:0] e;
    xfer(1'b1, 30'h20, 32'h5555AAAA, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    mdl[10'h20] = 32'h5555AAAA;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'h20; dat_w = 32'hDEADBEEF; sel = 4'hF; wait_cfg = 3'd5;
    seen_ack = 1'b0;
    @(posedge clk); #1;
    seen_ack |= ack;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_accept: got %b want 1", busy); end
    @(posedge clk); #1;
    seen_ack |= ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    seen_ack |= ack;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_fall: got %b want 0", busy); end
    repeat (8) begin @(posedge clk); #1; seen_ack |= ack; end
    total++; if (seen_ack !== 1'b0) begin bad++; $display("FAIL abort_no_ack: got %b want 0", seen_ack); end
    exp_q.push_back(mdl[10'h20]);
    xfer(1'b0, 30'h20, 32'h0, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL abort_ram_kept: got %h want %h", rd, e); end
  endtask

  task automatic test_irq();
    bit a; int l; logic [31:0] rd; logic ip, ia, wd; logic [31:0] e;
    xfer(1'b1, IRQ_A, 32'h1, 4'b0001, 3'd2, a, l, rd, ip, ia, wd);
    mdl_irq = 1'b1;
    total++; if (ip !== 1'b0)      begin bad++; $display("FAIL irq_before_ack: got %b want 0", ip); end
    total++; if (ia !== mdl_irq)   begin bad++; $display("FAIL irq_rise_with_ack: got %b want %b", ia, mdl_irq); end
    exp_q.push_back({31'b0, mdl_irq});
    xfer(1'b0, IRQ_A, 32'h0, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    e = exp_q.pop_front();
    total++; if (rd !== e)         begin bad++; $display("FAIL irq_read: got %h want %h", rd, e); end
    xfer(1'b1, IRQ_A, 32'h0, 4'b1110, 3'd0, a, l, rd, ip, ia, wd);
    total++; if (irq !== mdl_irq)  begin bad++; $display("FAIL irq_sel_no_lane0: got %b want %b", irq, mdl_irq); end
    xfer(1'b1, IRQ_A, 32'h0, 4'b0001, 3'd1, a, l, rd, ip, ia, wd);
    mdl_irq = 1'b0;
    total++; if (ia !== mdl_irq)   begin bad++; $display("FAIL irq_fall: got %b want %b", ia, mdl_irq); end
  endtask

  task automatic test_miss();
    bit a; int l; logic [31:0] rd; logic ip, ia, wd; logic [31:0] e;
    xfer(1'b1, 30'h0, 32'hC0FFEE11, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    mdl[0] = 32'hC0FFEE11;
    exp_q.push_back(32'h0);
    xfer(1'b0, 30'h1000_0000, 32'h0, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    e = exp_q.pop_front();
    total++; if (!a)       begin bad++; $display("FAIL miss_rd_ack: got 0 want 1"); end
    total++; if (rd !== e) begin bad++; $display("FAIL miss_rd_data: got %h want %h", rd, e); end
    xfer(1'b1, 30'h1000_0000, 32'hFFFFFFFF, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    total++; if (!a)       begin bad++; $display("FAIL miss_wr_ack: got 0 want 1"); end
    exp_q.push_back(mdl[0]);
    xfer(1'b0, 30'h0, 32'h0, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL miss_ram_kept: got %h want %h", rd, e); end
  endtask

  task automatic test_rst_mid();
    bit a; int l; logic [31:0] rd; logic ip, ia, wd; logic [31:0] e;
    xfer(1'b1, 30'h30, 32'h76543210, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    mdl[10'h30] = 32'h76543210;
    xfer(1'b1, IRQ_A, 32'h1, 4'b0001, 3'd0, a, l, rd, ip, ia, wd);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rst_irq_preset: got %b want 1", irq); end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'h30; dat_w = 32'h0BADF00D; sel = 4'hF; wait_cfg = 3'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mdl_irq = 1'b0;
    total++; if (ack !== 1'b0)     begin bad++; $display("FAIL rst_mid_ack: got %b want 0", ack); end
    total++; if (irq !== mdl_irq)  begin bad++; $display("FAIL rst_mid_irq: got %b want 0", irq); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_req_ignored: got busy=%b want 0", busy); end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    exp_q.push_back(mdl[10'h30]);
    xfer(1'b0, 30'h30, 32'h0, 4'hF, 3'd0, a, l, rd, ip, ia, wd);
    e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL rst_write_dropped: got %h want %h", rd, e); end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0; wait_cfg = '0;
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_wait_states();
    test_abort();
    test_irq();
    test_miss();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
